aes_rx_ctrl: RTL and testbench

AES_RX_CTRL -- requirements
Module: aes_rx_ctrl

---
 rtl/aes_ctrl_pkg.sv | 15 +
 rtl/aes_rx_ctrl_if.sv | 33 +++
 rtl/aes_rx_ctrl_byte_collector.sv | 54 +++++
 rtl/aes_rx_ctrl.sv | 105 ++++++++++
 tb/tb_aes_rx_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared constants for the AES receive controller.
// State encoding and block geometry used by the FSM and collector.
package aes_ctrl_pkg;

    localparam int BYTES_PER_BLOCK = 16;
    localparam int BLOCK_W         = 128;

    localparam logic [1:0] S_KEY   = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_START = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/aes_rx_ctrl_if.sv
// UART-side and AES-side signal bundle for aes_rx_ctrl.
// master drives the byte stream and core status, slave is the controller.
interface aes_rx_ctrl_if;
    import aes_ctrl_pkg::*;

    logic       Rx_DV_in;
    logic [7:0] Rx_Byte_in;
    logic       Key_Reload_in;
    logic       AES_Ready_in;
    logic       AES_Done_in;
    block_t     Key_out;
    block_t     Data_out;
    logic       Start_out;
    logic       Key_Valid_out;
    logic       Busy_out;
    logic       Overrun_out;
    logic       Timeout_out;

    modport master (
        output Rx_DV_in, Rx_Byte_in, Key_Reload_in,
        output AES_Ready_in, AES_Done_in,
        input  Key_out, Data_out, Start_out,
        input  Key_Valid_out, Busy_out, Overrun_out, Timeout_out
    );

    modport slave (
        input  Rx_DV_in, Rx_Byte_in, Key_Reload_in,
        input  AES_Ready_in, AES_Done_in,
        output Key_out, Data_out, Start_out,
        output Key_Valid_out, Busy_out, Overrun_out, Timeout_out
    );

endinterface

// File: rtl/aes_rx_ctrl_byte_collector.sv
// Shift register, byte counter and inter-byte idle timer.
// Flags the 16th byte and discards a stalled partial block.
module byte_collector
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CLKS    = 20000,
    parameter int BYTES_PER_BLOCK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       accept,
    input  logic       clear,
    input  logic [7:0] rx_byte,
    output logic       block_done,
    output block_t     word,
    output logic [3:0] count,
    output logic       timeout
);

    localparam int         TW   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS - 1);
    localparam logic [3:0] LAST = 4'(BYTES_PER_BLOCK - 1);

    block_t        shift;
    logic [TW-1:0] timer;

    assign word       = {shift[BLOCK_W-9:0], rx_byte};
    assign block_done = accept && (count == LAST);
    // A byte landing on the expiry cycle wins over the timeout.
    assign timeout    = en && !accept && (count != '0) && (timer == TMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
            count <= '0;
            timer <= '0;
        end else if (clear) begin
            count <= '0;
            timer <= '0;
        end else if (accept) begin
            shift <= word;
            count <= block_done ? '0 : count + 4'd1;
            timer <= '0;
        end else if (timeout) begin
            shift <= '0;
            count <= '0;
            timer <= '0;
        end else if (en && (count != '0)) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/aes_rx_ctrl.sv
// Receive controller: assembles UART bytes into AES key/data blocks
// and sequences start/done handshakes with the AES core.
module aes_rx_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CLKS    = 20000,
    parameter int BYTES_PER_BLOCK = aes_ctrl_pkg::BYTES_PER_BLOCK
) (
    input logic          CLK,
    input logic          RST,
    aes_rx_ctrl_if.slave bus
);

    logic [1:0] state;
    logic       collecting;
    logic       accept;
    logic       clear;
    logic       block_done;
    logic       timeout;
    block_t     word;
    logic [3:0] count;

    block_t key_q;
    block_t data_q;
    logic   start_q;
    logic   kv_q;
    logic   ovr_q;
    logic   tmo_q;

    assign collecting = (state == S_KEY) || (state == S_DATA);
    assign accept     = bus.Rx_DV_in && collecting;
    assign clear      = (state == S_WAIT) && bus.AES_Done_in;

    byte_collector #(
        .TIMEOUT_CLKS   (TIMEOUT_CLKS),
        .BYTES_PER_BLOCK(BYTES_PER_BLOCK)
    ) u_collector (
        .clk       (CLK),
        .rst       (RST),
        .en        (collecting),
        .accept    (accept),
        .clear     (clear),
        .rx_byte   (bus.Rx_Byte_in),
        .block_done(block_done),
        .word      (word),
        .count     (count),
        .timeout   (timeout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_KEY;
            key_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            kv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            tmo_q   <= timeout;
            if (bus.Rx_DV_in && !collecting)
                ovr_q <= 1'b1;
            unique case (state)
                S_KEY: begin
                    if (block_done) begin
                        key_q <= word;
                        kv_q  <= 1'b1;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (block_done) begin
                        data_q <= word;
                        state  <= S_START;
                    end else if (bus.Key_Reload_in && (count == '0)
                                 && !bus.Rx_DV_in) begin
                        kv_q  <= 1'b0;
                        state <= S_KEY;
                    end
                end
                S_START: begin
                    if (bus.AES_Ready_in) begin
                        start_q <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.AES_Done_in)
                        state <= S_DATA;
                end
                default: state <= S_KEY;
            endcase
        end
    end

    assign bus.Key_out       = key_q;
    assign bus.Data_out      = data_q;
    assign bus.Start_out     = start_q;
    assign bus.Key_Valid_out = kv_q;
    assign bus.Busy_out      = (state == S_START) || (state == S_WAIT);
    assign bus.Overrun_out   = ovr_q;
    assign bus.Timeout_out   = tmo_q;

endmodule

// File: tb/tb_aes_rx_ctrl.sv
// Scoreboard bench for aes_rx_ctrl: directed byte streams push expected
// key/start/timeout events; a negedge monitor pops and compares them.
module tb_aes_rx_ctrl;
    import aes_ctrl_pkg::*;

    localparam int T = 40;

    typedef enum int {EV_KEY, EV_START, EV_TMO} ev_e;
    typedef struct {
        ev_e    kind;
        block_t key;
        block_t data;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic kv_prev = 1'b0;

    always #5 CLK = ~CLK;

    aes_rx_ctrl_if bus();

    aes_rx_ctrl #(.TIMEOUT_CLKS(T)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    localparam block_t K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t D1 = 128'h00112233445566778899aabbccddeeff;
    localparam block_t D2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam block_t D3 = 128'h202122232425262728292a2b2c2d2e2f;
    localparam block_t DA = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
    localparam block_t K2 = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
    localparam block_t D4 = 128'h303132333435363738393a3b3c3d3e3f;
    localparam block_t K3 = 128'h404142434445464748494a4b4c4d4e4f;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic push(ev_e k, block_t key, block_t data);
        exp_t e;
        e.kind = k;
        e.key  = key;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic take(ev_e k, string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: actual unexpected event required none", name);
        end else begin
            e = sb.pop_front();
            check({name, "_kind"}, 128'(k), 128'(e.kind));
            if (k == EV_KEY)
                check({name, "_key"}, bus.Key_out, e.key);
            if (k == EV_START) begin
                check({name, "_data"}, bus.Data_out, e.data);
                check({name, "_key"}, bus.Key_out, e.key);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.Key_Valid_out && !kv_prev) take(EV_KEY, "key_event");
            if (bus.Start_out) take(EV_START, "start_event");
            if (bus.Timeout_out) take(EV_TMO, "timeout_event");
        end
        kv_prev = bus.Key_Valid_out;
    end

    task automatic tick(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(logic [7:0] b);
        bus.Rx_Byte_in = b;
        bus.Rx_DV_in   = 1'b1;
        tick(1);
        bus.Rx_DV_in   = 1'b0;
    endtask

    task automatic send_block(logic [7:0] base, logic [7:0] step);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = base + step * 8'(i);
            send(b);
        end
    endtask

    task automatic done_pulse();
        bus.AES_Done_in = 1'b1;
        tick(1);
        bus.AES_Done_in = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_key"},   bus.Key_out, '0);
        check({tag, "_data"},  bus.Data_out, '0);
        check({tag, "_start"}, 128'(bus.Start_out), 0);
        check({tag, "_kv"},    128'(bus.Key_Valid_out), 0);
        check({tag, "_busy"},  128'(bus.Busy_out), 0);
        check({tag, "_ovr"},   128'(bus.Overrun_out), 0);
        check({tag, "_tmo"},   128'(bus.Timeout_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        bus.Rx_DV_in      = 1'b0;
        bus.Rx_Byte_in    = 8'h00;
        bus.Key_Reload_in = 1'b0;
        bus.AES_Ready_in  = 1'b0;
        bus.AES_Done_in   = 1'b0;
        tick(3);
        check_all_zero("reset");
        RST = 1'b0;
        tick(1);
        bus.AES_Ready_in = 1'b1;

        push(EV_KEY, K1, '0);
        send_block(8'h00, 8'h01);
        check("key_valid", 128'(bus.Key_Valid_out), 1);
        check("key_value", bus.Key_out, K1);
        check("key_no_start", 128'(bus.Start_out), 0);
        check("key_not_busy", 128'(bus.Busy_out), 0);

        push(EV_START, K1, D1);
        send_block(8'h00, 8'h11);
        check("lat_start_low", 128'(bus.Start_out), 0);
        check("lat_busy", 128'(bus.Busy_out), 1);
        tick(1);
        check("lat_start_high", 128'(bus.Start_out), 1);
        tick(1);
        check("start_one_cycle", 128'(bus.Start_out), 0);
        tick(4);
        check("busy_wait", 128'(bus.Busy_out), 1);
        done_pulse();
        check("busy_clear", 128'(bus.Busy_out), 0);
        check("key_kept", bus.Key_out, K1);

        bus.AES_Ready_in = 1'b0;
        push(EV_START, K1, D2);
        send_block(8'hf0, 8'h01);
        tick(3);
        check("hold_no_start", 128'(bus.Start_out), 0);
        check("hold_busy", 128'(bus.Busy_out), 1);
        check("ovr_still_low", 128'(bus.Overrun_out), 0);
        bus.AES_Ready_in = 1'b1;
        tick(1);
        check("ready_start", 128'(bus.Start_out), 1);
        send(8'h55);
        check("overrun_set", 128'(bus.Overrun_out), 1);
        done_pulse();
        push(EV_START, K1, D3);
        send_block(8'h20, 8'h01);
        tick(3);
        check("overrun_sticky", 128'(bus.Overrun_out), 1);
        done_pulse();

        push(EV_TMO, '0, '0);
        for (int i = 1; i <= 5; i++) send(8'(i));
        tick(T + 5);
        push(EV_START, K1, DA);
        send(8'haa);
        tick(T - 1);
        for (int i = 0; i < 15; i++) send(8'haa);
        tick(3);
        check("aa_busy", 128'(bus.Busy_out), 1);
        done_pulse();

        bus.Key_Reload_in = 1'b1;
        tick(1);
        bus.Key_Reload_in = 1'b0;
        check("reload_kv_low", 128'(bus.Key_Valid_out), 0);
        push(EV_KEY, K2, '0);
        send_block(8'hc0, 8'h01);
        check("reload_kv_high", 128'(bus.Key_Valid_out), 1);
        check("reload_key", bus.Key_out, K2);
        for (int i = 0; i < 8; i++) send(8'h80 + 8'(i));
        bus.Key_Reload_in = 1'b1;
        tick(1);
        bus.Key_Reload_in = 1'b0;
        check("reload_ignored", 128'(bus.Key_Valid_out), 1);
        RST = 1'b1;
        tick(1);
        check_all_zero("midblock_rst");
        RST = 1'b0;

        push(EV_KEY, K1, '0);
        send_block(8'h00, 8'h01);
        push(EV_START, K1, D4);
        send_block(8'h30, 8'h01);
        tick(3);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        done_pulse();
        check("rst_wait_busy", 128'(bus.Busy_out), 0);
        check("rst_wait_kv", 128'(bus.Key_Valid_out), 0);
        push(EV_KEY, K3, '0);
        send_block(8'h40, 8'h01);
        tick(5);
        check("scoreboard_drained", 128'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
